d_ff: RTL and testbench

//   Synchronous-reset D flip-flop / register primitive: samples d on each rising clk edge and presents it on q.

---
 rtl/d_ff_pkg.sv | 12 +
 rtl/d_ff_if.sv | 14 +
 rtl/d_ff_stage.sv | 35 +++
 rtl/d_ff.sv | 39 +++
 tb/tb_d_ff.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/d_ff_pkg.sv
// Shared constants and the parameter sanity check used by the d_ff register primitive.
// Both the top and the single-stage register elaborate against the same limits.
package d_ff_pkg;

  localparam int MIN_WIDTH  = 1;
  localparam int MIN_STAGES = 1;

  function automatic bit params_ok(input int width, input int stages);
    return (width >= MIN_WIDTH) && (stages >= MIN_STAGES);
  endfunction

endpackage

// File: rtl/d_ff_if.sv
// Bundle of the data/reset signals around one d_ff instance.
// The driver side owns d and reset; the register side owns q.
interface d_ff_if #(
  parameter int WIDTH = 1
);

  logic             reset;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output reset, output d, input  q);
  modport slave  (input  reset, input  d, output q);

endinterface

// File: rtl/d_ff_stage.sv
// Single synchronous-reset register; reset wins over d at the clock edge.
module d_ff_stage
  import d_ff_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (!params_ok(WIDTH, MIN_STAGES)) begin : g_bad_width
    $fatal(1, "d_ff_stage: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/d_ff.sv
// Synchronous-reset register / short delay line: STAGES chained d_ff_stage registers,
// q is the output of the last one, so latency d->q is exactly STAGES clocks.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $fatal(1, "d_ff: WIDTH and STAGES must both be >= 1");
  end

  // chain[0] is the input; chain[i+1] is the output of stage i.
  logic [STAGES:0][WIDTH-1:0] chain;

  assign chain[0] = d;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .d     (chain[i]),
      .q     (chain[i+1])
    );
  end

  assign q = chain[STAGES];

endmodule

// File: tb/tb_d_ff.sv
// Scoreboard bench for d_ff: a default 1-bit/1-stage instance and an 8-bit/3-stage/A5 instance,
// each checked against a history-window reference model.
module tb_d_ff;
  import d_ff_pkg::*;

  localparam int         WB  = 8;
  localparam int         SB  = 3;
  localparam logic [7:0] RVB = 8'hA5;

  typedef struct {
    bit         rst;
    logic [7:0] d;
  } hist_t;

  typedef struct {
    logic [7:0] val;
    bit         known;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  d_ff_if #(.WIDTH(1))  ia ();
  d_ff_if #(.WIDTH(WB)) ib ();

  d_ff dut_a (
    .clk   (clk),
    .reset (ia.reset),
    .d     (ia.d),
    .q     (ia.q)
  );

  d_ff #(
    .WIDTH       (WB),
    .STAGES      (SB),
    .RESET_VALUE (RVB)
  ) dut_b (
    .clk   (clk),
    .reset (ib.reset),
    .d     (ib.d),
    .q     (ib.q)
  );

  int n_run  = 0;
  int n_fail = 0;

  hist_t hist_a[$];
  hist_t hist_b[$];
  exp_t  exp_qa[$];
  exp_t  exp_qb[$];

  // q after an edge is RESET_VALUE if any of the last `stages` edges saw reset,
  // otherwise the d sampled `stages` edges back (unknown if history is too short).
  function automatic exp_t model(input hist_t h[$], input int stages, input logic [7:0] rv);
    exp_t e;
    int   n;
    int   lo;
    e.val   = '0;
    e.known = 1'b0;
    n  = h.size();
    lo = (n > stages) ? n - stages : 0;
    for (int k = lo; k < n; k++) begin
      if (h[k].rst) begin
        e.val   = rv;
        e.known = 1'b1;
      end
    end
    if (!e.known && n >= stages) begin
      e.val   = h[n-stages].d;
      e.known = 1'b1;
    end
    return e;
  endfunction

  // Stimulus recorder: every edge's sampled inputs go into history and an expectation is queued.
  always @(posedge clk) begin
    hist_a.push_back('{rst: ia.reset, d: {7'b0, ia.d}});
    hist_b.push_back('{rst: ib.reset, d: ib.d});
    if (hist_a.size() > 8) void'(hist_a.pop_front());
    if (hist_b.size() > 8) void'(hist_b.pop_front());
    exp_qa.push_back(model(hist_a, 1, 8'h00));
    exp_qb.push_back(model(hist_b, SB, RVB));
  end

  // Monitor: samples q just after each edge and checks against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_qa.size() == 0) begin
      n_run++; n_fail++;
      $display("FAIL q_a_queue_empty at t=%0t", $time);
    end else begin
      e = exp_qa.pop_front();
      if (e.known) begin
        n_run++;
        if (ia.q !== e.val[0]) begin
          n_fail++;
          $display("FAIL q_a at t=%0t: got %b expected %b", $time, ia.q, e.val[0]);
        end
      end
    end
    if (exp_qb.size() == 0) begin
      n_run++; n_fail++;
      $display("FAIL q_b_queue_empty at t=%0t", $time);
    end else begin
      e = exp_qb.pop_front();
      if (e.known) begin
        n_run++;
        if (ib.q !== e.val) begin
          n_fail++;
          $display("FAIL q_b at t=%0t: got %h expected %h", $time, ib.q, e.val);
        end
      end
    end
  end

  task automatic cyc(input logic ra, input logic da, input logic rb, input logic [7:0] db);
    @(posedge clk);
    #3;
    ia.reset = ra; ia.d = da;
    ib.reset = rb; ib.d = db;
  endtask

  // Reset pulse entirely between edges; it must never be seen by either register.
  task automatic glitch(input logic da, input logic [7:0] db);
    @(posedge clk);
    #2;
    ia.d = da; ib.d = db;
    ia.reset = 1'b1; ib.reset = 1'b1;
    #3;
    ia.reset = 1'b0; ib.reset = 1'b0;
  endtask

  initial begin
    ia.reset = 1'b0; ia.d = 1'b0;
    ib.reset = 1'b1; ib.d = 8'h00;

    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 0, 8'h3C);
    cyc(0, 0, 0, 8'h11);
    cyc(0, 0, 0, 8'h22);
    cyc(0, 1, 1, 8'h33);
    cyc(0, 0, 0, 8'h44);
    repeat (10) cyc(0, 0, 0, 8'h44);
    cyc(1, 1, 1, 8'hFF);
    cyc(0, 1, 0, 8'h5A);
    glitch(1, 8'h66);
    glitch(0, 8'h77);
    cyc(0, 1, 0, 8'h88);
    cyc(0, 0, 0, 8'h99);
    cyc(0, 0, 0, 8'hAA);

    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 15)) == 0) begin
        glitch(1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        cyc(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0), 8'($urandom));
      end
    end

    repeat (4) @(posedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
